// File: rtl/m_trap_ctrl.sv
// M-mode trap controller: machine CSRs, trap entry/mret sequencing and prioritised interrupts.
// Optional TRAP_COUNTERS_EN adds mcycle/minstret; undefined leaves those addresses illegal.
module m_trap_ctrl #(
  parameter int unsigned NUM_LOCAL   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RESET_TVEC  = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [11:0]                               csr_addr,
  input  logic [1:0]                                csr_mode,
  input  logic [31:0]                               csr_din,
  output logic [31:0]                               csr_dout,
  output logic                                      csr_illegal,
  input  logic                                      exc_valid,
  input  logic [4:0]                                exc_cause,
  input  logic [31:0]                               exc_tval,
  input  logic [31:0]                               epc,
  input  logic                                      boundary,
  input  logic                                      mret,
  input  logic                                      irq_ext,
  input  logic                                      irq_sw,
  input  logic                                      irq_timer,
  input  logic [((NUM_LOCAL > 0) ? NUM_LOCAL : 1)-1:0] irq_local,
  output logic                                      trap_valid,
  output logic [31:0]                               trap_pc,
  output logic [31:0]                               mepc_o
);

  localparam int unsigned LocalW = (NUM_LOCAL > 0) ? NUM_LOCAL : 1;
  localparam int unsigned IrqW   = LocalW + 3;

  function automatic logic [31:0] gen_irq_mask();
    logic [31:0] m;
    m = 32'h0000_0888;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(NUM_LOCAL)) m[16+i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [31:0] IrqMask = gen_irq_mask();

  logic              status_mie_q, status_mie_d;
  logic              status_mpie_q, status_mpie_d;
  logic [31:0]       mie_q, mie_d;
  logic [31:0]       mtvec_q, mtvec_d;
  logic [31:0]       mscratch_q, mscratch_d;
  logic [31:0]       mepc_q, mepc_d;
  logic [31:0]       mcause_q, mcause_d;
  logic [31:0]       mtval_q, mtval_d;
  logic              msip_q, msip_d;
  logic              trap_valid_q, trap_valid_d;
  logic [31:0]       trap_pc_q, trap_pc_d;

  logic [IrqW-1:0]   irq_raw, irq_s;
  logic [31:0]       mip, pend, mstatus_rd, wdata;
  logic [4:0]        irq_code;
  logic              irq_any, take_exc, take_ret, take_irq, csr_we;

`ifdef TRAP_COUNTERS_EN
  logic [63:0]       mcycle_q, mcycle_d;
  logic [63:0]       minstret_q, minstret_d;
`endif

  // Bit order: ext, sw, timer, then the local lines.
  assign irq_raw = {irq_local, irq_timer, irq_sw, irq_ext};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign irq_s = irq_raw;
  end else begin : g_sync
    logic [IrqW-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= irq_raw;
        for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign irq_s = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    mip     = '0;
    mip[11] = irq_s[0];
    mip[3]  = irq_s[1] | msip_q;
    mip[7]  = irq_s[2];
    for (int i = 0; i < int'(NUM_LOCAL); i++) mip[16+i] = irq_s[3+i];
  end

  assign pend    = status_mie_q ? (mip & mie_q) : 32'd0;
  assign irq_any = |pend;

  // Ascending scan so the highest local index wins, then the fixed lines override.
  always_comb begin
    irq_code = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (pend[16+i]) irq_code = 5'(16 + i);
    end
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  // The cycle after a redirect is a flush cycle: nothing is accepted.
  assign take_exc = exc_valid & ~trap_valid_q;
  assign take_ret = mret & ~exc_valid & ~trap_valid_q;
  assign take_irq = boundary & irq_any & ~exc_valid & ~mret & ~trap_valid_q;
  assign csr_we   = (csr_mode != 2'b00) & ~csr_illegal & ~trap_valid_q & ~exc_valid & ~mret &
                    ~take_irq;

  assign mstatus_rd = {19'd0, 2'b11, 3'd0, status_mpie_q, 3'd0, status_mie_q, 3'd0};

  always_comb begin
    csr_dout    = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      12'h300: csr_dout = mstatus_rd;
      12'h301: csr_dout = MISA_VAL;
      12'h304: csr_dout = mie_q;
      12'h305: csr_dout = mtvec_q;
      12'h340: csr_dout = mscratch_q;
      12'h341: csr_dout = mepc_q;
      12'h342: csr_dout = mcause_q;
      12'h343: csr_dout = mtval_q;
      12'h344: csr_dout = mip;
`ifdef TRAP_COUNTERS_EN
      12'hB00: csr_dout = mcycle_q[31:0];
      12'hB80: csr_dout = mcycle_q[63:32];
      12'hB02: csr_dout = minstret_q[31:0];
      12'hB82: csr_dout = minstret_q[63:32];
`endif
      default: csr_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (csr_mode)
      2'b01:   wdata = csr_din;
      2'b10:   wdata = csr_dout | csr_din;
      2'b11:   wdata = csr_dout & ~csr_din;
      default: wdata = csr_dout;
    endcase
  end

  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    msip_d        = msip_q;
    trap_valid_d  = 1'b0;
    trap_pc_d     = trap_pc_q;
    if (take_exc) begin
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
      mepc_d        = epc & 32'hFFFF_FFFC;
      mcause_d      = {27'd0, exc_cause};
      mtval_d       = exc_tval;
      trap_valid_d  = 1'b1;
      trap_pc_d     = {mtvec_q[31:2], 2'b00};
    end else if (take_ret) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
      trap_valid_d  = 1'b1;
      trap_pc_d     = mepc_q;
    end else if (take_irq) begin
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
      mepc_d        = epc & 32'hFFFF_FFFC;
      mcause_d      = {1'b1, 26'd0, irq_code};
      mtval_d       = '0;
      trap_valid_d  = 1'b1;
      trap_pc_d     = {mtvec_q[31:2], 2'b00} + (mtvec_q[0] ? {25'd0, irq_code, 2'b00} : 32'd0);
    end else if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          status_mie_d  = wdata[3];
          status_mpie_d = wdata[7];
        end
        12'h304: mie_d      = wdata & IrqMask;
        12'h305: mtvec_d    = wdata[1] ? {wdata[31:2], 2'b00} : wdata;
        12'h340: mscratch_d = wdata;
        12'h341: mepc_d     = wdata & 32'hFFFF_FFFC;
        12'h342: mcause_d   = wdata;
        12'h343: mtval_d    = wdata;
        12'h344: msip_d     = wdata[3];
        default: ;
      endcase
    end
  end

`ifdef TRAP_COUNTERS_EN
  // A half-write replaces that half and freezes the other for the cycle.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, boundary};
    if (csr_we) begin
      case (csr_addr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], wdata};
        12'hB80: mcycle_d   = {wdata, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wdata};
        12'hB82: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= RESET_TVEC;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      msip_q        <= 1'b0;
      trap_valid_q  <= 1'b0;
      trap_pc_q     <= '0;
    end else begin
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      msip_q        <= msip_d;
      trap_valid_q  <= trap_valid_d;
      trap_pc_q     <= trap_pc_d;
    end
  end

  // Reset cancels a redirect that is already on the output.
  assign trap_valid = trap_valid_q & ~rst;
  assign trap_pc    = trap_pc_q;
  assign mepc_o     = mepc_q;

endmodule

// File: tb/tb_m_trap_ctrl.sv
// Bench for m_trap_ctrl: directed scenarios plus random stimulus against a CSR-level
// reference model (lines delayed two samples, priority list, trap rules).
module tb_m_trap_ctrl;

  localparam logic [31:0] TVEC = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_mode;
  logic [31:0] csr_din, csr_dout;
  logic        csr_illegal;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_tval, epc;
  logic        boundary, mret, irq_ext, irq_sw, irq_timer;
  logic [15:0] irq_local;
  logic        trap_valid;
  logic [31:0] trap_pc, mepc_o;

  always #10 clk = ~clk;

  m_trap_ctrl #(
    .NUM_LOCAL  (16),
    .SYNC_STAGES(2),
    .RESET_TVEC (TVEC),
    .MISA_VAL   (32'h4000_0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_addr   (csr_addr),
    .csr_mode   (csr_mode),
    .csr_din    (csr_din),
    .csr_dout   (csr_dout),
    .csr_illegal(csr_illegal),
    .exc_valid  (exc_valid),
    .exc_cause  (exc_cause),
    .exc_tval   (exc_tval),
    .epc        (epc),
    .boundary   (boundary),
    .mret       (mret),
    .irq_ext    (irq_ext),
    .irq_sw     (irq_sw),
    .irq_timer  (irq_timer),
    .irq_local  (irq_local),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .mepc_o     (mepc_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic        m_mie_en, m_mpie, m_msip, m_tv;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_tpc;
  logic [31:0] line_q[$];  // raw lines in mip bit positions, oldest first

  function automatic logic [31:0] raw_lines();
    return (32'(irq_ext) << 11) | (32'(irq_sw) << 3) | (32'(irq_timer) << 7) |
           (32'(irq_local) << 16);
  endfunction

  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, 32'h1800 | (32'(m_mie_en) << 3) | (32'(m_mpie) << 7)};
      12'h301: return {1'b0, 32'h4000_0100};
      12'h304: return {1'b0, m_mie};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h343: return {1'b0, m_mtval};
      12'h344: return {1'b0, line_q[0] | (32'(m_msip) << 3)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int pick_irq(input logic [31:0] p);
    if (p[11]) return 11;
    if (p[3]) return 3;
    if (p[7]) return 7;
    for (int i = 31; i >= 16; i--) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mie_en = 0; m_mpie = 0; m_msip = 0; m_tv = 0;
    m_mie = 0; m_mtvec = TVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_tpc = 0;
    line_q = '{32'h0, 32'h0};
  endtask

  task automatic model_step();
    logic [32:0] rd;
    logic [31:0] pend, nv;
    logic        flush;
    int          code;
    if (rst) begin
      model_reset();
      return;
    end
    flush = m_tv;
    m_tv  = 0;
    pend  = m_mie_en ? ((line_q[0] | (32'(m_msip) << 3)) & m_mie) : 32'h0;
    code  = pick_irq(pend);
    rd    = m_read(csr_addr);
    if (flush) begin
    end else if (exc_valid) begin
      m_mpie = m_mie_en; m_mie_en = 0;
      m_mepc = epc & ~32'h3; m_mcause = 32'(exc_cause); m_mtval = exc_tval;
      m_tpc = m_mtvec & ~32'h3; m_tv = 1;
    end else if (mret) begin
      m_mie_en = m_mpie; m_mpie = 1;
      m_tpc = m_mepc; m_tv = 1;
    end else if (boundary && code >= 0) begin
      m_mpie = m_mie_en; m_mie_en = 0;
      m_mepc = epc & ~32'h3; m_mcause = 32'h8000_0000 | 32'(code); m_mtval = 0;
      m_tpc = (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * code) : 32'h0); m_tv = 1;
    end else if (csr_mode != 2'b00 && !rd[32]) begin
      case (csr_mode)
        2'b01:   nv = csr_din;
        2'b10:   nv = rd[31:0] | csr_din;
        default: nv = rd[31:0] & ~csr_din;
      endcase
      case (csr_addr)
        12'h300: begin m_mie_en = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie = nv & 32'hFFFF_0888;
        12'h305: m_mtvec = (nv[1:0] >= 2) ? (nv & ~32'h3) : nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'h344: m_msip = nv[3];
        default: ;
      endcase
    end
    line_q.push_back(raw_lines());
    void'(line_q.pop_front());
  endtask

  // One clock: combinational checks at negedge, registered checks just after posedge.
  task automatic cycle();
    logic [32:0] rd;
    @(negedge clk);
    rd = m_read(csr_addr);
    check("csr_dout", csr_dout, rd[31:0]);
    check("csr_illegal", 32'(csr_illegal), 32'(rd[32]));
    check("tv_now", 32'(trap_valid), 32'(m_tv & ~rst));
    @(posedge clk);
    model_step();
    #1;
    check("trap_valid", 32'(trap_valid), 32'(m_tv));
    check("trap_pc", trap_pc, m_tpc);
    check("mepc", mepc_o, m_mepc);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
    csr_addr = a; csr_mode = m; csr_din = d;
    cycle();
    csr_mode = 2'b00;
  endtask

  task automatic expect_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a; csr_mode = 2'b00;
    #1;
    check(tag, csr_dout, exp);
  endtask

  task automatic wait_trap(input string tag, input logic [31:0] exp_pc);
    logic seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      cycle();
      seen = trap_valid;
    end
    check({tag, "_seen"}, 32'(seen), 32'h1);
    check({tag, "_pc"}, trap_pc, exp_pc);
  endtask

  task automatic mret_pulse();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
  endtask

  initial begin
    rst = 1; csr_addr = 0; csr_mode = 0; csr_din = 0; exc_valid = 0; exc_cause = 0;
    exc_tval = 0; epc = 0; boundary = 0; mret = 0; irq_ext = 0; irq_sw = 0; irq_timer = 0;
    irq_local = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 0;

    expect_csr("rst_mstatus", 12'h300, 32'h0000_1800);
    expect_csr("rst_mtvec", 12'h305, TVEC);
    expect_csr("rst_mip", 12'h344, 32'h0);
    expect_csr("rst_misa", 12'h301, 32'h4000_0100);
    expect_csr("illegal_dout", 12'h7C0, 32'h0);
    check("illegal_flag", 32'(csr_illegal), 32'h1);
    idle(1);

    // Vectored timer interrupt
    csr_op(12'h305, 2'b01, 32'h0000_0101);
    csr_op(12'h304, 2'b10, 32'h0000_0080);
    csr_op(12'h300, 2'b10, 32'h0000_0008);
    irq_timer = 1; boundary = 1;
    wait_trap("mti", 32'h0000_011C);
    expect_csr("mti_mcause", 12'h342, 32'h8000_0007);
    expect_csr("mti_mstatus", 12'h300, 32'h0000_1880);
    irq_timer = 0; boundary = 0;
    idle(3);

    // mret
    csr_op(12'h341, 2'b01, 32'h0000_2000);
    mret_pulse();
    check("mret_tv", 32'(trap_valid), 32'h1);
    check("mret_pc", trap_pc, 32'h0000_2000);
    expect_csr("mret_mstatus", 12'h300, 32'h0000_1888);
    idle(1);

    // Exception beats pending MEI and a same-cycle CSR write
    csr_op(12'h304, 2'b10, 32'h0000_0800);
    irq_ext = 1;
    idle(3);
    boundary = 1; exc_valid = 1; exc_cause = 5'd2; exc_tval = 32'h0000_DEAD; epc = 32'h3000;
    csr_addr = 12'h340; csr_mode = 2'b01; csr_din = 32'h1234;
    cycle();
    exc_valid = 0; csr_mode = 0; boundary = 0;
    check("exc_tv", 32'(trap_valid), 32'h1);
    check("exc_pc", trap_pc, 32'h0000_0100);
    expect_csr("exc_mcause", 12'h342, 32'h2);
    expect_csr("exc_mtval", 12'h343, 32'h0000_DEAD);
    expect_csr("exc_mscratch", 12'h340, 32'h0);
    irq_ext = 0;
    idle(3);

    // MTI, then local 9, then local 3
    csr_op(12'h304, 2'b01, 32'h0208_0080);
    irq_timer = 1; irq_local = 16'h0208;
    csr_op(12'h300, 2'b10, 32'h0000_0008);
    boundary = 1;
    wait_trap("lcl_mti", 32'h0000_011C);
    irq_timer = 0;
    idle(3);
    mret_pulse();
    wait_trap("lcl9", 32'h0000_0164);
    irq_local = 16'h0008;
    idle(3);
    mret_pulse();
    wait_trap("lcl3", 32'h0000_014C);
    irq_local = 0; boundary = 0;
    idle(3);

    // Write/set/clear and WARL fields
    csr_op(12'h304, 2'b01, 32'hFFFF_FFFF);
    expect_csr("mie_write", 12'h304, 32'hFFFF_0888);
    csr_op(12'h304, 2'b11, 32'h0000_0888);
    expect_csr("mie_clear", 12'h304, 32'hFFFF_0000);
    csr_op(12'h304, 2'b10, 32'h0000_0008);
    expect_csr("mie_set", 12'h304, 32'hFFFF_0008);
    csr_op(12'h305, 2'b01, 32'h0000_0203);
    expect_csr("mtvec_warl", 12'h305, 32'h0000_0200);
    csr_op(12'h341, 2'b01, 32'h0000_1237);
    expect_csr("mepc_warl", 12'h341, 32'h0000_1234);
    csr_op(12'h304, 2'b01, 32'h0);

    // Reset while a redirect is on the output
    exc_valid = 1;
    cycle();
    exc_valid = 0;
    check("pre_rst_tv", 32'(trap_valid), 32'h1);
    rst = 1;
    #1;
    check("rst_cancel", 32'(trap_valid), 32'h0);
    cycle();
    rst = 0;
    expect_csr("post_rst_mtvec", 12'h305, TVEC);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic [11:0] addrs [12];
      addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                12'h344, 12'h7C0, 12'hB00, 12'h000};
      csr_addr  = addrs[$urandom_range(0, 11)];
      csr_mode  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      csr_din   = $urandom;
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_cause = 5'($urandom);
      exc_tval  = $urandom;
      epc       = $urandom;
      mret      = ($urandom_range(0, 11) == 0);
      boundary  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
      if ($urandom_range(0, 7) == 0) irq_sw = ~irq_sw;
      if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 7) == 0) irq_local = irq_local ^ (16'h1 << $urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
